ms_timeout_timer: RTL

Programmable millisecond-granularity timeout timer clocked by the ms_clk output of the clock divider. Link-training and sideband FSMs use it to measure protocol timeouts in ms_clk ticks: tLinkTraining, SB transaction timeout, and retry intervals. It supports one-shot and periodic modes, pause, abort, and restart. It provides a registered single-cycle timeout pulse and a sticky expired flag.

---
 rtl/usb4_timer_pkg.sv | 17 +
 rtl/ms_timeout_timer.sv | 109 ++++++++++
 2 files changed

// File: rtl/usb4_timer_pkg.sv
// Shared definitions for the ms-tick timeout timer: state encoding, default
// counter width and the standard protocol timeouts in ms_clk ticks.
package usb4_timer_pkg;

   localparam int CNT_W_DEFAULT = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int T_LINK_TRAINING  = 500;
   localparam int T_SB_TRANSACTION = 10;
   localparam int T_RETRY          = 25;

endpackage

// File: rtl/ms_timeout_timer.sv
// Programmable ms-tick timeout timer with one-shot/periodic modes, pause,
// abort and restart. All outputs come straight from registers.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | not counting (after reset, abort, or zero-length periodic)
//   RUN     | counting ticks toward target, busy high
//   DONE    | one-shot expired, elapsed parked at target, waits for start/abort
module ms_timeout_timer
   import usb4_timer_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             ms_clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] timeout_val_i,
   input  logic             periodic_i,
   input  logic             pause_i,
   input  logic             abort_i,
   output logic             timeout_o,
   output logic             expired_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] elapsed_o
);

   state_t           state_q,    state_d;
   logic [CNT_W-1:0] elapsed_q,  elapsed_d;
   logic [CNT_W-1:0] target_q,   target_d;
   logic             periodic_q, periodic_d;
   logic             timeout_q,  timeout_d;
   logic             expired_q,  expired_d;
   logic             busy_q,     busy_d;
   logic [CNT_W-1:0] last_tick;

   // target is never zero while in RUN, so target-1 cannot underflow there
   assign last_tick = target_q - CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      elapsed_d  = elapsed_q;
      target_d   = target_q;
      periodic_d = periodic_q;
      expired_d  = expired_q;
      busy_d     = busy_q;
      timeout_d  = 1'b0;
      if (abort_i) begin
         state_d   = ST_IDLE;
         elapsed_d = '0;
         expired_d = 1'b0;
         busy_d    = 1'b0;
      end else if (start_i) begin
         target_d   = timeout_val_i;
         periodic_d = periodic_i;
         elapsed_d  = '0;
         if (timeout_val_i != '0) begin
            expired_d = 1'b0;
            busy_d    = 1'b1;
            state_d   = ST_RUN;
         end else begin
            // zero length expires at once; periodic would free-run, so park in IDLE
            timeout_d = 1'b1;
            expired_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = periodic_i ? ST_IDLE : ST_DONE;
         end
      end else if (state_q == ST_RUN && !pause_i) begin
         if (elapsed_q == last_tick) begin
            timeout_d = 1'b1;
            expired_d = 1'b1;
            if (periodic_q) begin
               elapsed_d = '0;
            end else begin
               elapsed_d = target_q;
               busy_d    = 1'b0;
               state_d   = ST_DONE;
            end
         end else begin
            elapsed_d = elapsed_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge ms_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         elapsed_q  <= '0;
         target_q   <= '0;
         periodic_q <= 1'b0;
         timeout_q  <= 1'b0;
         expired_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         elapsed_q  <= elapsed_d;
         target_q   <= target_d;
         periodic_q <= periodic_d;
         timeout_q  <= timeout_d;
         expired_q  <= expired_d;
         busy_q     <= busy_d;
      end
   end

   assign timeout_o = timeout_q;
   assign expired_o = expired_q;
   assign busy_o    = busy_q;
   assign elapsed_o = elapsed_q;

endmodule
